// File: rtl/root_process_inverse.sv
// Streaming inverse of RootProcess: recovers A = XOUT + MULT*B + BIAS (mod 2^NBITS)
// through a 2-stage valid/ready pipeline, with a wrapping delivered-word counter.
module root_process_inverse #(
    parameter int NBITS   = 8,
    parameter int MULT    = 3,
    parameter int BIAS    = 21,
    parameter int CNTBITS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [NBITS-1:0]   i_xout_in,
    input  logic [NBITS-1:0]   i_b_in,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [NBITS-1:0]   o_a_out,
    output logic [NBITS-1:0]   o_b_out,
    output logic [CNTBITS-1:0] o_out_count
);
    localparam logic [NBITS-1:0] MULT_N = NBITS'(MULT);
    localparam logic [NBITS-1:0] BIAS_N = NBITS'(BIAS);

    logic               r_v1;
    logic [NBITS-1:0]   r_p1;
    logic [NBITS-1:0]   r_s1;
    logic [NBITS-1:0]   r_b1;
    logic               r_v2;
    logic [NBITS-1:0]   r_a2;
    logic [NBITS-1:0]   r_b2;
    logic [CNTBITS-1:0] r_count;
    logic               w_adv1;
    logic               w_adv2;

    // Ready ripples back combinationally so a full, flowing pipe never stalls.
    assign w_adv2     = !r_v2 || i_out_ready;
    assign w_adv1     = !r_v1 || w_adv2;
    assign o_in_ready = w_adv1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v1    <= 1'b0;
            r_p1    <= '0;
            r_s1    <= '0;
            r_b1    <= '0;
            r_v2    <= 1'b0;
            r_a2    <= '0;
            r_b2    <= '0;
            r_count <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= i_in_valid;
                if (i_in_valid) begin
                    // Product truncated to NBITS before the add, as the forward block does.
                    r_p1 <= MULT_N * i_b_in;
                    r_s1 <= i_xout_in + BIAS_N;
                    r_b1 <= i_b_in;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_a2 <= r_s1 + r_p1;
                    r_b2 <= r_b1;
                end
            end
            if (r_v2 && i_out_ready) begin
                r_count <= r_count + CNTBITS'(1);
            end
        end
    end

    assign o_out_valid = r_v2;
    assign o_a_out     = r_a2;
    assign o_b_out     = r_b2;
    assign o_out_count = r_count;
endmodule
